ex_mem_reg: RTL and testbench

//   EX->MEM pipeline register. Captures EX-stage write-back results (dest reg, write enable, data, HI/LO)
//   and presents them to the MEM stage one cycle later. Implements stall and flush and bubble insertion.

---
 rtl/ex_mem_if.sv | 62 ++++++
 rtl/ex_mem_reg.sv | 81 ++++++++
 tb/tb_ex_mem_reg.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/ex_mem_if.sv
// ex_mem_if: bundle of the EX-side results entering the EX->MEM register
// and the registered MEM-side copies leaving it.
// Build option: EXMEM_HILO_EN adds the HI/LO path and the multi-cycle
// multiply-accumulate loopback (step count and 64-bit partial product).
interface ex_mem_if #(
    parameter int DW = 32,
    parameter int AW = 5
`ifdef EXMEM_HILO_EN
   ,parameter int CW = 2
`endif
);
    // EX stage results
    logic [AW-1:0]   ex_wd;
    logic            ex_wreg;
    logic [DW-1:0]   ex_wdata;
`ifdef EXMEM_HILO_EN
    logic            ex_whilo;
    logic [DW-1:0]   ex_hi;
    logic [DW-1:0]   ex_lo;
    logic [CW-1:0]   ex_cnt;
    logic [2*DW-1:0] ex_hilo_tmp;
`endif

    // Registered copies presented to MEM (and loopback to EX)
    logic            mem_valid;
    logic [AW-1:0]   mem_wd;
    logic            mem_wreg;
    logic [DW-1:0]   mem_wdata;
`ifdef EXMEM_HILO_EN
    logic            mem_whilo;
    logic [DW-1:0]   mem_hi;
    logic [DW-1:0]   mem_lo;
    logic [CW-1:0]   cnt_o;
    logic [2*DW-1:0] hilo_tmp_o;
`endif

`ifdef EXMEM_HILO_EN
    // EX side: drives results, observes the registered slot and loopback
    modport master (
        output ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo, ex_cnt, ex_hilo_tmp,
        input  mem_valid, mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
               cnt_o, hilo_tmp_o
    );
    // Pipeline register side
    modport slave (
        input  ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo, ex_cnt, ex_hilo_tmp,
        output mem_valid, mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
               cnt_o, hilo_tmp_o
    );
`else
    // EX side: drives results, observes the registered slot
    modport master (
        output ex_wd, ex_wreg, ex_wdata,
        input  mem_valid, mem_wd, mem_wreg, mem_wdata
    );
    // Pipeline register side
    modport slave (
        input  ex_wd, ex_wreg, ex_wdata,
        output mem_valid, mem_wd, mem_wreg, mem_wdata
    );
`endif
endinterface

// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX->MEM pipeline register with stall, flush and bubble insert.
// All outputs are registered, one cycle of latency from EX to MEM.
// Edge priority: reset, flush, bubble (EX stalled, MEM free), capture
// (EX not stalled), otherwise hold (both stalled).
// Build option: EXMEM_HILO_EN adds HI/LO capture and the multi-cycle
// count / partial-product loopback that EX reads back while it is stalled.
module ex_mem_reg (
    input  logic     clk,
    input  logic     rst,
    input  logic     flush,
    input  logic     stall_ex,
    input  logic     stall_mem,
    ex_mem_if.slave  bus
);
    // Slot occupancy; mem_valid is a direct view of the registered state.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    slot_state_e state;

    logic do_clear;
    logic do_bubble;
    logic do_capture;

    // Decode the per-edge action. A MEM stall without an EX stall cannot
    // legally happen; it falls into capture so upstream work is never lost.
    always_comb begin
        do_clear   = rst | flush;
        do_bubble  = !do_clear && stall_ex && !stall_mem;
        do_capture = !do_clear && !stall_ex;
    end

    // Slot state and GPR path; bubble and clear both leave a zeroed slot.
    always_ff @(posedge clk) begin
        if (do_clear || do_bubble) begin
            state         <= EMPTY;
            bus.mem_wd    <= '0;
            bus.mem_wreg  <= 1'b0;
            bus.mem_wdata <= '0;
        end else if (do_capture) begin
            state         <= FULL;
            bus.mem_wd    <= bus.ex_wd;
            bus.mem_wreg  <= bus.ex_wreg;
            bus.mem_wdata <= bus.ex_wdata;
        end
        // both stalled: hold everything
    end

    assign bus.mem_valid = (state == FULL);

`ifdef EXMEM_HILO_EN
    // HI/LO path and multi-cycle loopback. The bubble cycle is where EX
    // parks its in-flight step count and partial product; capture retires
    // the op and clears them, and a flush forces the op to restart.
    always_ff @(posedge clk) begin
        if (do_clear) begin
            bus.mem_whilo  <= 1'b0;
            bus.mem_hi     <= '0;
            bus.mem_lo     <= '0;
            bus.cnt_o      <= '0;
            bus.hilo_tmp_o <= '0;
        end else if (do_bubble) begin
            bus.mem_whilo  <= 1'b0;
            bus.mem_hi     <= '0;
            bus.mem_lo     <= '0;
            bus.cnt_o      <= bus.ex_cnt;
            bus.hilo_tmp_o <= bus.ex_hilo_tmp;
        end else if (do_capture) begin
            bus.mem_whilo  <= bus.ex_whilo;
            bus.mem_hi     <= bus.ex_hi;
            bus.mem_lo     <= bus.ex_lo;
            bus.cnt_o      <= '0;
            bus.hilo_tmp_o <= '0;
        end
        // both stalled: hold, loopback included
    end
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// tb_ex_mem_reg: directed self-checking bench for ex_mem_reg.
// Covers both builds; HI/LO and loopback checks exist only with EXMEM_HILO_EN.
module tb_ex_mem_reg;
    logic clk = 1'b0;
    logic rst, flush, stall_ex, stall_mem;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ex_mem_if #(.DW(32), .AW(5)) bus ();

    ex_mem_reg dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .stall_ex  (stall_ex),
        .stall_mem (stall_mem),
        .bus       (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one edge; outputs are settled 1ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_gpr(input string tag, input logic v, input logic [4:0] wd,
                           input logic wr, input logic [31:0] d);
        chk({tag, ".valid"}, 64'(bus.mem_valid), 64'(v));
        chk({tag, ".wd"},    64'(bus.mem_wd),    64'(wd));
        chk({tag, ".wreg"},  64'(bus.mem_wreg),  64'(wr));
        chk({tag, ".wdata"}, 64'(bus.mem_wdata), 64'(d));
    endtask

`ifdef EXMEM_HILO_EN
    task automatic chk_hilo(input string tag, input logic wh, input logic [31:0] hi,
                            input logic [31:0] lo, input logic [1:0] cnt, input logic [63:0] tmp);
        chk({tag, ".whilo"}, 64'(bus.mem_whilo), 64'(wh));
        chk({tag, ".hi"},    64'(bus.mem_hi),    64'(hi));
        chk({tag, ".lo"},    64'(bus.mem_lo),    64'(lo));
        chk({tag, ".cnt"},   64'(bus.cnt_o),     64'(cnt));
        chk({tag, ".tmp"},   bus.hilo_tmp_o,     tmp);
    endtask
`endif

    initial begin
        rst = 1'b1; flush = 1'b0; stall_ex = 1'b0; stall_mem = 1'b0;
        bus.ex_wd = 5'd31; bus.ex_wreg = 1'b1; bus.ex_wdata = 32'hFFFF_FFFF;
`ifdef EXMEM_HILO_EN
        bus.ex_whilo = 1'b1; bus.ex_hi = 32'hFFFF_FFFF; bus.ex_lo = 32'hFFFF_FFFF;
        bus.ex_cnt = 2'd3; bus.ex_hilo_tmp = 64'hFFFF_FFFF_FFFF_FFFF;
`endif
        // 1: reset dominates live inputs
        step(); step();
        chk_gpr("rst", 1'b0, 5'd0, 1'b0, 32'h0);
`ifdef EXMEM_HILO_EN
        chk_hilo("rst", 1'b0, 32'h0, 32'h0, 2'd0, 64'h0);
`endif

        // 2: plain capture
        rst = 1'b0;
        bus.ex_wd = 5'd3; bus.ex_wreg = 1'b1; bus.ex_wdata = 32'h1234_5678;
`ifdef EXMEM_HILO_EN
        bus.ex_whilo = 1'b1; bus.ex_hi = 32'hAAAA_0001; bus.ex_lo = 32'h5555_0002;
        bus.ex_cnt = 2'd2; bus.ex_hilo_tmp = 64'h1;
`endif
        step();
        chk_gpr("cap", 1'b1, 5'd3, 1'b1, 32'h1234_5678);
`ifdef EXMEM_HILO_EN
        chk_hilo("cap", 1'b1, 32'hAAAA_0001, 32'h5555_0002, 2'd0, 64'h0);
`endif

        // 3: hold for three cycles while inputs change
        stall_ex = 1'b1; stall_mem = 1'b1;
        bus.ex_wd = 5'd7; bus.ex_wreg = 1'b0; bus.ex_wdata = 32'hDEAD_BEEF;
`ifdef EXMEM_HILO_EN
        bus.ex_whilo = 1'b0; bus.ex_hi = 32'h0; bus.ex_lo = 32'h0;
`endif
        for (int i = 0; i < 3; i++) begin
            step();
            chk_gpr($sformatf("hold%0d", i), 1'b1, 5'd3, 1'b1, 32'h1234_5678);
        end
`ifdef EXMEM_HILO_EN
        chk_hilo("hold", 1'b1, 32'hAAAA_0001, 32'h5555_0002, 2'd0, 64'h0);
`endif

        // 5: flush beats a double stall on a full slot
        flush = 1'b1;
        step();
        chk_gpr("flush", 1'b0, 5'd0, 1'b0, 32'h0);
`ifdef EXMEM_HILO_EN
        chk_hilo("flush", 1'b0, 32'h0, 32'h0, 2'd0, 64'h0);
`endif
        flush = 1'b0;

        // 4: bubble, loopback stepping, hold keeps loopback, then capture
        stall_ex = 1'b1; stall_mem = 1'b0;
        bus.ex_wd = 5'd9; bus.ex_wreg = 1'b1; bus.ex_wdata = 32'hCAFE_0009;
`ifdef EXMEM_HILO_EN
        bus.ex_whilo = 1'b1; bus.ex_hi = 32'h1111_1111; bus.ex_lo = 32'h2222_2222;
        bus.ex_cnt = 2'd1; bus.ex_hilo_tmp = 64'h0000_0001_0000_0002;
`endif
        step();
        chk_gpr("bub1", 1'b0, 5'd0, 1'b0, 32'h0);
`ifdef EXMEM_HILO_EN
        chk_hilo("bub1", 1'b0, 32'h0, 32'h0, 2'd1, 64'h0000_0001_0000_0002);
        bus.ex_cnt = 2'd2; bus.ex_hilo_tmp = 64'h0000_0003_0000_0004;
        step();
        chk_hilo("bub2", 1'b0, 32'h0, 32'h0, 2'd2, 64'h0000_0003_0000_0004);
        stall_mem = 1'b1; bus.ex_cnt = 2'd3; bus.ex_hilo_tmp = 64'h5;
        step();
        chk_hilo("bubhold", 1'b0, 32'h0, 32'h0, 2'd2, 64'h0000_0003_0000_0004);
        stall_mem = 1'b0;
`endif
        stall_ex = 1'b0;
        step();
        chk_gpr("bubcap", 1'b1, 5'd9, 1'b1, 32'hCAFE_0009);
`ifdef EXMEM_HILO_EN
        chk_hilo("bubcap", 1'b1, 32'h1111_1111, 32'h2222_2222, 2'd0, 64'h0);

        // flush mid-sequence clears the loopback
        stall_ex = 1'b1;
        bus.ex_cnt = 2'd1; bus.ex_hilo_tmp = 64'h77;
        step();
        chk_hilo("midseq", 1'b0, 32'h0, 32'h0, 2'd1, 64'h77);
        flush = 1'b1;
        step();
        chk_hilo("midflush", 1'b0, 32'h0, 32'h0, 2'd0, 64'h0);
        flush = 1'b0;
`endif

        // illegal MEM-only stall behaves as capture
        stall_ex = 1'b0; stall_mem = 1'b1;
        bus.ex_wd = 5'd17; bus.ex_wreg = 1'b0; bus.ex_wdata = 32'h0BAD_F00D;
        step();
        chk_gpr("memonly", 1'b1, 5'd17, 1'b0, 32'h0BAD_F00D);

        // back-to-back captures with full-width patterns
        stall_mem = 1'b0;
        bus.ex_wd = 5'd31; bus.ex_wreg = 1'b1; bus.ex_wdata = 32'hFFFF_FFFF;
        step();
        chk_gpr("b2b0", 1'b1, 5'd31, 1'b1, 32'hFFFF_FFFF);
        bus.ex_wd = 5'd0; bus.ex_wreg = 1'b1; bus.ex_wdata = 32'h8000_0001;
        step();
        chk_gpr("b2b1", 1'b1, 5'd0, 1'b1, 32'h8000_0001);

        // reset beats a capture
        rst = 1'b1;
        step();
        chk_gpr("rst2", 1'b0, 5'd0, 1'b0, 32'h0);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
